// File: rtl/arbitro_div_pkg.sv
// Shared definitions for the divider arbiter: state encoding and default sizes.
package arbitro_div_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int WIDTH_DEF   = 16;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LANZA   = 3'd1,
        ESPERA  = 3'd2,
        ENTREGA = 3'd3,
        LIBERA  = 3'd4
    } estado_t;

    // Next round-robin position after a given winner, with cyclic wrap.
    function automatic int siguiente(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/arbitro_divisor_if.sv
// Client and divider bundle for arbitro_divisor; master = arbiter, slave = environment.
interface arbitro_divisor_if
    import arbitro_div_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF
);
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] dividendo_in;
    logic [N_REQ*WIDTH-1:0] divisor_in;
    logic [N_REQ-1:0]       ack;
    logic [WIDTH-1:0]       cociente_out;
    logic [WIDTH-1:0]       residuo_out;
    logic                   div_cero_out;
    logic                   ocupado;
    logic [IW-1:0]          grant_id;
    logic                   div_go;
    logic [WIDTH-1:0]       div_dividendo;
    logic [WIDTH-1:0]       div_divisor;
    logic                   div_listo;
    logic [WIDTH-1:0]       div_cociente;
    logic [WIDTH-1:0]       div_residuo;
    logic                   div_error;

    modport master (
        input  req, dividendo_in, divisor_in,
        input  div_listo, div_cociente, div_residuo, div_error,
        output ack, cociente_out, residuo_out, div_cero_out, ocupado, grant_id,
        output div_go, div_dividendo, div_divisor
    );

    modport slave (
        output req, dividendo_in, divisor_in,
        output div_listo, div_cociente, div_residuo, div_error,
        input  ack, cociente_out, residuo_out, div_cero_out, ocupado, grant_id,
        input  div_go, div_dividendo, div_divisor
    );

endinterface

// File: rtl/arbitro_divisor_selector_rr.sv
// selector_rr: combinational round-robin picker, first set req bit at or after rr_ptr.
module selector_rr
    import arbitro_div_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic                     hit,
    output logic [$clog2(N_REQ)-1:0] idx
);
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0] rot;
    int               off;
    int               suma;

    always_comb begin
        // Rotate so bit 0 is the requester at rr_ptr, then pick the lowest set bit.
        rot  = N_REQ'({req, req} >> rr_ptr);
        hit  = |req;
        off  = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = k;
        end
        suma = int'(rr_ptr) + off;
        if (suma >= N_REQ) suma = suma - N_REQ;
        idx  = IW'(suma);
    end

endmodule

// File: rtl/arbitro_divisor.sv
// arbitro_divisor: round-robin arbiter/sequencer sharing one divider among N_REQ clients.
// Define ARBITRO_DIV_TIMEOUT_EN to add the ESPERA watchdog and the sticky timeout_err port.
module arbitro_divisor
    import arbitro_div_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF
`ifdef ARBITRO_DIV_TIMEOUT_EN
    ,
    parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
    input  logic reloj,
    input  logic reset,
`ifdef ARBITRO_DIV_TIMEOUT_EN
    output logic timeout_err,
`endif
    arbitro_divisor_if.master bus
);
    localparam int IW = $clog2(N_REQ);

    estado_t          estado, estado_sig;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    sel_idx;
    logic             sel_hit;
    logic [WIDTH-1:0] coc_q, res_q;
    logic             err_q;
    logic             wd_fin;

    selector_rr #(.N_REQ(N_REQ)) u_sel (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .hit    (sel_hit),
        .idx    (sel_idx)
    );

`ifdef ARBITRO_DIV_TIMEOUT_EN
    logic [7:0] wd_cnt;

    assign wd_fin = (wd_cnt == 8'(TIMEOUT - 1));

    // Counter restarts on every entry to ESPERA; the error flag is sticky until reset.
    always_ff @(negedge reloj or negedge reset) begin
        if (!reset) begin
            wd_cnt      <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            wd_cnt <= (estado == ESPERA) ? wd_cnt + 8'd1 : 8'd0;
            if (estado == ESPERA && !bus.div_listo && wd_fin)
                timeout_err <= 1'b1;
        end
    end
`else
    assign wd_fin = 1'b0;
`endif

    always_ff @(negedge reloj or negedge reset) begin
        if (!reset) begin
            estado            <= IDLE;
            rr_ptr            <= '0;
            bus.ocupado       <= 1'b0;
            bus.grant_id      <= '0;
            bus.div_dividendo <= '0;
            bus.div_divisor   <= '0;
        end else begin
            estado      <= estado_sig;
            bus.ocupado <= (estado_sig != IDLE);
            if (estado == IDLE && sel_hit) begin
                bus.grant_id      <= sel_idx;
                bus.div_dividendo <= bus.dividendo_in[sel_idx*WIDTH +: WIDTH];
                bus.div_divisor   <= bus.divisor_in[sel_idx*WIDTH +: WIDTH];
            end
            if (estado == ENTREGA)
                rr_ptr <= IW'(siguiente(int'(bus.grant_id), N_REQ));
        end
    end

    // Result holding registers are only observed through ENTREGA, so they need no reset.
    always_ff @(negedge reloj) begin
        if (estado == ESPERA) begin
            if (bus.div_listo) begin
                coc_q <= bus.div_cociente;
                res_q <= bus.div_residuo;
                err_q <= bus.div_error;
            end else if (wd_fin) begin
                coc_q <= '0;
                res_q <= '0;
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            IDLE:    if (sel_hit) estado_sig = LANZA;
            LANZA:   estado_sig = ESPERA;
            ESPERA:  if (bus.div_listo || wd_fin) estado_sig = ENTREGA;
            ENTREGA: estado_sig = LIBERA;
            LIBERA:  if (!bus.div_listo) estado_sig = IDLE;
            default: estado_sig = IDLE;
        endcase
    end

    always_comb begin
        bus.ack          = '0;
        bus.cociente_out = '0;
        bus.residuo_out  = '0;
        bus.div_cero_out = 1'b0;
        bus.div_go       = (estado == LANZA) || (estado == ESPERA);
        if (estado == ENTREGA) begin
            bus.ack[bus.grant_id] = 1'b1;
            bus.cociente_out      = coc_q;
            bus.residuo_out       = res_q;
            bus.div_cero_out      = err_q;
        end
    end

endmodule

// File: tb/tb_arbitro_divisor.sv
// Bench for arbitro_divisor: directed scenarios plus random traffic against a round-robin model.
module tb_arbitro_divisor;
    import arbitro_div_pkg::*;

    localparam int N = 4;
    localparam int W = 16;

    logic reloj = 1'b0;
    logic reset = 1'b0;
    always #5 reloj = ~reloj;

    arbitro_divisor_if #(.N_REQ(N), .WIDTH(W)) bus ();

`ifdef ARBITRO_DIV_TIMEOUT_EN
    logic timeout_err;
`endif

    arbitro_divisor #(.N_REQ(N), .WIDTH(W)) dut (
        .reloj       (reloj),
        .reset       (reset),
`ifdef ARBITRO_DIV_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .bus         (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int ptr_m = 0;
    logic [W-1:0] op_a [N];
    logic [W-1:0] op_b [N];

    // Divider stand-in: fixed busy time, listo held until go drops plus an optional tail.
    int lat = 1, hold = 0, dv_cnt = 0, dv_hold = 0;
    bit nunca = 1'b0;

    always @(negedge reloj or negedge reset) begin
        if (!reset) begin
            bus.div_listo    <= 1'b0;
            bus.div_cociente <= '0;
            bus.div_residuo  <= '0;
            bus.div_error    <= 1'b0;
            dv_cnt           <= 0;
            dv_hold          <= 0;
        end else if (bus.div_go) begin
            dv_hold <= 0;
            if (!bus.div_listo && !nunca) begin
                if (dv_cnt >= lat) begin
                    dv_cnt        <= 0;
                    bus.div_listo <= 1'b1;
                    if (bus.div_divisor == '0) begin
                        bus.div_cociente <= '1;
                        bus.div_residuo  <= bus.div_dividendo;
                        bus.div_error    <= 1'b1;
                    end else begin
                        bus.div_cociente <= bus.div_dividendo / bus.div_divisor;
                        bus.div_residuo  <= bus.div_dividendo % bus.div_divisor;
                        bus.div_error    <= 1'b0;
                    end
                end else begin
                    dv_cnt <= dv_cnt + 1;
                end
            end
        end else begin
            dv_cnt <= 0;
            if (bus.div_listo) begin
                if (dv_hold >= hold) bus.div_listo <= 1'b0;
                else dv_hold <= dv_hold + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ganador(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++)
            if (m[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic cargar();
        for (int i = 0; i < N; i++) begin
            bus.dividendo_in[i*W +: W] = op_a[i];
            bus.divisor_in[i*W +: W]   = op_b[i];
        end
    endtask

    task automatic nuevo_op(input int i);
        op_a[i] = W'($urandom);
        op_b[i] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 300));
    endtask

    // Wait for the next ack and compare it with the round-robin model and exact division.
    task automatic atender(input string tag, input logic [N-1:0] mascara, output int quien);
        int c;
        int g;
        logic [31:0] ec, er, ez;
        quien = -1;
        c = 0;
        do begin
            @(posedge reloj);
            c++;
        end while (bus.ack == '0 && c < 300);
        chk({tag, "_ack_llega"}, 32'(|bus.ack), 1);
        if (bus.ack != '0) begin
            g = ganador(mascara, ptr_m);
            if (g >= 0) begin
                if (op_b[g] == '0) begin
                    ec = 32'hffff; er = 32'(op_a[g]); ez = 1;
                end else begin
                    ec = 32'(int'(op_a[g]) / int'(op_b[g]));
                    er = 32'(int'(op_a[g]) % int'(op_b[g]));
                    ez = 0;
                end
                chk({tag, "_ack"},      32'(bus.ack), 32'(1) << g);
                chk({tag, "_grant"},    32'(bus.grant_id), 32'(g));
                chk({tag, "_cociente"}, 32'(bus.cociente_out), ec);
                chk({tag, "_residuo"},  32'(bus.residuo_out), er);
                chk({tag, "_cero"},     32'(bus.div_cero_out), ez);
                ptr_m = (g + 1) % N;
            end
            quien = g;
        end
    endtask

    task automatic tras_ack(input string tag);
        @(posedge reloj);
        chk({tag, "_pulso"}, 32'(bus.ack), 0);
    endtask

    task automatic esperar_idle(input string tag);
        int c;
        c = 0;
        while (bus.ocupado && c < 50) begin
            @(posedge reloj);
            c++;
        end
        chk({tag, "_idle"}, 32'(bus.ocupado), 0);
    endtask

    task automatic todo_cero(input string tag);
        chk({tag, "_ack"},      32'(bus.ack), 0);
        chk({tag, "_cociente"}, 32'(bus.cociente_out), 0);
        chk({tag, "_residuo"},  32'(bus.residuo_out), 0);
        chk({tag, "_cero"},     32'(bus.div_cero_out), 0);
        chk({tag, "_ocupado"},  32'(bus.ocupado), 0);
        chk({tag, "_grant"},    32'(bus.grant_id), 0);
        chk({tag, "_go"},       32'(bus.div_go), 0);
        chk({tag, "_op_a"},     32'(bus.div_dividendo), 0);
        chk({tag, "_op_b"},     32'(bus.div_divisor), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int q, c, it;
        int ord [5];
        logic [N-1:0] m;
        ord = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        cargar();
        bus.req = '0;

        repeat (3) @(posedge reloj);
        todo_cero("reset");
`ifdef ARBITRO_DIV_TIMEOUT_EN
        chk("reset_timeout_err", 32'(timeout_err), 0);
`endif
        reset = 1'b1;
        repeat (2) @(posedge reloj);

        // Single requester 2: 100 / 7.
        op_a[2] = 16'd100; op_b[2] = 16'd7; cargar();
        bus.req = 4'b0100;
        atender("t1", 4'b0100, q);
        chk("t1_cociente_14", 32'(bus.cociente_out), 14);
        chk("t1_residuo_2",   32'(bus.residuo_out), 2);
        chk("t1_grant_2",     32'(bus.grant_id), 2);
        bus.req = '0;
        tras_ack("t1");
        esperar_idle("t1");

        // All four held, pointer freshly reset: service order 0,1,2,3,0.
        reset = 1'b0;
        @(posedge reloj);
        reset = 1'b1;
        ptr_m = 0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = 16'd50; op_b[i] = 16'd5;
        end
        cargar();
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            atender("t2", 4'b1111, q);
            chk("t2_orden", 32'(q), 32'(ord[i]));
            chk("t2_cociente_10", 32'(bus.cociente_out), 10);
        end
        bus.req = '0;
        tras_ack("t2");
        esperar_idle("t2");

        // Divide by zero; LIBERA must hold until the divider drops listo.
        hold = 3;
        op_a[1] = 16'd9; op_b[1] = 16'd0; cargar();
        bus.req = 4'b0010;
        atender("t3", 4'b0010, q);
        chk("t3_cero_1", 32'(bus.div_cero_out), 1);
        bus.req = '0;
        tras_ack("t3");
        c = 0;
        while (bus.div_listo && c < 20) begin
            chk("t3_ocupado_listo", 32'(bus.ocupado), 1);
            chk("t3_go_libera", 32'(bus.div_go), 0);
            @(posedge reloj);
            c++;
        end
        chk("t3_listo_retenido", 32'(c >= 2), 1);
        chk("t3_ocupado_ultimo", 32'(bus.ocupado), 1);
        @(posedge reloj);
        chk("t3_vuelve_idle", 32'(bus.ocupado), 0);
        hold = 0;

        // Reset while waiting on a slow divide aborts with no ack.
        lat = 20;
        op_a[0] = 16'd1000; op_b[0] = 16'd3; cargar();
        bus.req = 4'b0001;
        c = 0;
        while (!bus.div_go && c < 20) begin
            @(posedge reloj);
            c++;
        end
        chk("t4_go_visto", 32'(bus.div_go), 1);
        repeat (3) @(posedge reloj);
        #2;
        reset = 1'b0;
        op_a[3] = 16'd77; op_b[3] = 16'd7; cargar();
        bus.req = 4'b1000;
        #1;
        todo_cero("t4_abort");
        repeat (3) begin
            @(posedge reloj);
            chk("t4_sin_ack", 32'(bus.ack), 0);
        end
        reset = 1'b1;
        ptr_m = 0;
        lat = 2;
        atender("t4", 4'b1000, q);
        chk("t4_primero_3", 32'(q), 3);
        bus.req = '0;
        tras_ack("t4");
        esperar_idle("t4");

        // Requester 0 stays high after its ack; 1 must win next.
        op_a[0] = 16'd40; op_b[0] = 16'd6;
        op_a[1] = 16'd33; op_b[1] = 16'd4; cargar();
        bus.req = 4'b0011;
        atender("t5a", 4'b0011, q);
        chk("t5_primero_0", 32'(q), 0);
        atender("t5b", 4'b0011, q);
        chk("t5_segundo_1", 32'(q), 1);
        bus.req = '0;
        tras_ack("t5");
        esperar_idle("t5");

        // Random traffic: requesters come and go, some re-request right after service.
        for (int r = 0; r < 40; r++) begin
            lat  = $urandom_range(0, 4);
            hold = $urandom_range(0, 2);
            m = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) if (m[i]) nuevo_op(i);
            cargar();
            bus.req = m;
            it = 0;
            while (m != '0 && it < 16) begin
                atender("rnd", m, q);
                it++;
                if (q < 0) break;
                if ($urandom_range(0, 3) == 0) nuevo_op(q);
                else m[q] = 1'b0;
                c = $urandom_range(0, N - 1);
                if (!m[c] && $urandom_range(0, 2) == 0) begin
                    m[c] = 1'b1;
                    nuevo_op(c);
                end
                cargar();
                bus.req = m;
            end
            bus.req = '0;
            esperar_idle("rnd");
        end
        hold = 0;

`ifdef ARBITRO_DIV_TIMEOUT_EN
        // Divider never answers: watchdog forces delivery after 64 cycles in ESPERA.
        nunca = 1'b1;
        op_a[2] = 16'd5; op_b[2] = 16'd1; cargar();
        bus.req = 4'b0100;
        c = 0;
        while (!bus.div_go && c < 20) begin
            @(posedge reloj);
            c++;
        end
        c = 0;
        while (bus.ack == '0 && c < 200) begin
            if (bus.div_go) c++;
            @(posedge reloj);
        end
        chk("to_ciclos_go", 32'(c), 65);
        chk("to_ack", 32'(bus.ack), 32'(4'b0100));
        chk("to_cero", 32'(bus.div_cero_out), 1);
        chk("to_cociente", 32'(bus.cociente_out), 0);
        chk("to_residuo", 32'(bus.residuo_out), 0);
        chk("to_err", 32'(timeout_err), 1);
        bus.req = '0;
        nunca = 1'b0;
        tras_ack("to");
        esperar_idle("to");
        chk("to_err_pegajoso", 32'(timeout_err), 1);
        reset = 1'b0;
        #1;
        chk("to_err_reset", 32'(timeout_err), 0);
        @(posedge reloj);
        reset = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/arbitro_divisor.md
# arbitro_divisor

Round-robin arbiter and sequencer that shares one 16-bit shift-subtract divider unit between up to N_REQ requesters. It latches the winning requester's operands and drives the divider's go/done handshake. It returns quotient, remainder and divide-by-zero status to the winner with a one-cycle ack pulse. It sits between the client blocks and the divider datapath/FSM pair, which it treats as a single resource.

## Interface
- N_REQ, 4: number of requesters (2..8).
- WIDTH, 16: operand/result width.
- TIMEOUT, 64: watchdog limit in cycles (only with macro, see Configuration).
- reloj  in  1  clock; all registers update on the falling edge.
- reset  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  level request per requester.
- dividendo_in  in  N_REQ*WIDTH  packed dividends; slice i belongs to req[i].
- divisor_in  in  N_REQ*WIDTH  packed divisors.
- ack  out  N_REQ  one-cycle pulse to the served requester.
- cociente_out, residuo_out  out  WIDTH each  result bus, valid only while ack != 0.
- div_cero_out  out  1  divide-by-zero flag, valid with ack.
- ocupado  out  1  high whenever the state is not IDLE.
- grant_id  out  clog2(N_REQ)  index of the current or last winner.
- div_go  out  1  go to the divider.
- div_dividendo, div_divisor  out  WIDTH each  latched operands to the divider.
- div_listo  in  1  divider done (high in its final state until go drops).
- div_cociente, div_residuo  in  WIDTH each  divider results.
- div_error  in  1  divider saw a zero divisor.

## Operation
- States: IDLE, LANZA, ESPERA, ENTREGA, LIBERA.
- IDLE: if req != 0, select the winner: the first set bit at or after rr_ptr, with cyclic wrap. Latch grant_id and that slice's operands, then go to LANZA.
- LANZA: div_go=1, then go to ESPERA.
- ESPERA: div_go stays 1. When div_listo=1, latch div_cociente, div_residuo and div_error, then go to ENTREGA.
- ENTREGA: div_go=0. ack[grant_id]=1 and results are driven. rr_ptr = grant_id+1 (wraps to 0 after N_REQ-1). Go to LIBERA.
- LIBERA: wait for div_listo=0, then go to IDLE.
- req is sampled only in IDLE. A requester must hold req and its operands stable until its ack.
- A requester that drops req on the edge after its ack is not re-served. LIBERA guarantees at least one cycle between ack and the next arbitration.
- Divisor 0: the divider asserts done with error. The block passes this through as div_cero_out=1. Quotient and remainder are forwarded unmodified.
- Outputs other than ack, result bus and div_go are registered. ack and the result bus are decoded from the state plus latched registers.

## Timing
- Reset values: all outputs 0, rr_ptr=0, state IDLE. Reset mid-operation aborts without an ack; the divider shares the same reset.
- Minimum latency from req seen in IDLE to ack is 3 edges plus the divider busy time. Back-to-back service costs LIBERA plus IDLE: at least 2 cycles.
- Simultaneous requests: exactly one grant per arbitration. Every active requester is served within N_REQ transactions.
- div_go is never high in ENTREGA or LIBERA. div_listo is ignored outside ESPERA and LIBERA.

## Configuration
- ARBITRO_DIV_TIMEOUT_EN defined:
  - An 8-bit watchdog counts cycles in ESPERA.
  - When it reaches TIMEOUT without div_listo, the block enters ENTREGA with div_cero_out=1 and results 0.
  - The sticky output timeout_err goes to 1 and is cleared only by reset.
- Undefined: no counter and no timeout_err port. ESPERA waits indefinitely.

## Structure
- Shared package arbitro_div_pkg holds the state encoding constants, default N_REQ/WIDTH and the TIMEOUT default.
- Sub-module selector_rr: combinational rotate-and-priority picker. Inputs are req and rr_ptr; outputs are hit and idx.

## Test plan
- Single req[2], 100/7 -> ack[2] one cycle, cociente 14, residuo 2, div_cero 0, grant_id 2.
- req=4'b1111 held, all with 50/5 -> acks in order 0,1,2,3,0, each with cociente 10, residuo 0.
- req[1], 9/0 -> ack[1], div_cero_out 1, then the block returns to IDLE only after div_listo drops.
- Reset asserted during ESPERA -> all outputs 0 at once, no ack; after release, a pending req[3] is served first (rr_ptr 0, only req[3] set).
- Macro on, divider model never asserts listo -> ack after TIMEOUT=64 cycles in ESPERA, div_cero 1, timeout_err 1.
- req[0] kept high after its ack with req[1] also high -> next grant goes to 1, not 0.
